// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one byte per XMitGo/TxEmpty handshake, sent as
// start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       XMitGo,
  input  logic [7:0] TxData,
  output logic       TxD,
  output logic       TxEmpty
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_serializer: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_serializer: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          stop_q, stop_d;
  logic          txd_q, txd_d;
  logic          tx_empty_q, tx_empty_d;
  logic          bit_end;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      stop_q     <= 1'b0;
      txd_q      <= 1'b1;
      tx_empty_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      stop_q     <= stop_d;
      txd_q      <= txd_d;
      tx_empty_q <= tx_empty_d;
    end
  end

  // TxD is computed one edge ahead so it is always a clean registered output.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    stop_d     = stop_q;
    txd_d      = txd_q;
    tx_empty_d = tx_empty_q;
    bit_end    = (baud_q == LAST);

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        txd_d      = 1'b1;
        tx_empty_d = 1'b1;
        if (XMitGo) begin
          shift_d    = TxData;
          parity_d   = (^TxData) ^ (PARITY == 2);
          txd_d      = 1'b0;
          tx_empty_d = 1'b0;
          baud_d     = '0;
          stop_d     = 1'b0;
          state_d    = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bit_idx_d = '0;
          txd_d     = shift_q[0];
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q != 3'd7) begin
            txd_d = shift_q[1];
          end else if (PARITY != 0) begin
            txd_d   = parity_q;
            state_d = S_PARITY;
          end else begin
            txd_d   = 1'b1;
            state_d = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          txd_d   = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          // With two stop bits the first boundary only flips the stop counter.
          if (STOP_BITS == 2 && !stop_q) begin
            stop_d = 1'b1;
          end else begin
            stop_d     = 1'b0;
            tx_empty_d = 1'b1;
            state_d    = S_IDLE;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        txd_d      = 1'b1;
        tx_empty_d = 1'b1;
      end
    endcase
  end

  assign TxD     = txd_q;
  assign TxEmpty = tx_empty_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: five parameterisations driven
// side by side, checked every cycle against a frame-level line model.
module tb_uart_tx_serializer;

  localparam int NI = 5;
  localparam int CPB_A [NI] = '{4, 4, 4, 4, 50};
  localparam int PAR_A [NI] = '{0, 1, 2, 0, 0};
  localparam int STP_A [NI] = '{1, 1, 1, 2, 1};

  logic       Clock;
  logic       Reset;
  logic       xmit_go  [NI];
  logic [7:0] tx_data  [NI];
  logic       txd      [NI];
  logic       tx_empty [NI];

  int         vectors     = 0;
  int         miscompares = 0;
  bit         check_en    = 0;
  int         pos   [NI];
  logic [11:0] fbits [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    uart_tx_serializer #(
      .CLKS_PER_BIT(CPB_A[g]),
      .PARITY      (PAR_A[g]),
      .STOP_BITS   (STP_A[g])
    ) u_dut (
      .Clock  (Clock),
      .Reset  (Reset),
      .XMitGo (xmit_go[g]),
      .TxData (tx_data[g]),
      .TxD    (txd[g]),
      .TxEmpty(tx_empty[g])
    );
  end

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Line levels of one frame, bit period by bit period; unused slots are high.
  function automatic logic [11:0] frameBits(input int i, input logic [7:0] d);
    logic [11:0] b;
    b    = '1;
    b[0] = 1'b0;
    for (int k = 0; k < 8; k++) b[k+1] = d[k];
    if (PAR_A[i] != 0) b[9] = (^d) ^ (PAR_A[i] == 2);
    return b;
  endfunction

  function automatic int frameLen(input int i);
    return CPB_A[i] * (9 + ((PAR_A[i] != 0) ? 1 : 0) + STP_A[i]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NI; i++) begin
      xmit_go[i] = ($urandom_range(0, 3) == 0);
      tx_data[i] = 8'($urandom);
    end
    Reset = ($urandom_range(0, 299) == 0);
  endtask

  task automatic waitEmpty(input int i, input string name);
    int n = 0;
    while (tx_empty[i] !== 1'b1 && n < 2000) begin
      @(negedge Clock);
      n++;
    end
    checkOutput(name, 32'(tx_empty[i]), 1);
  endtask

  task automatic measureFrame(input int i, input logic [7:0] d,
                              output int low, output logic [11:0] seq);
    seq        = '0;
    low        = 0;
    xmit_go[i] = 1'b1;
    tx_data[i] = d;
    @(negedge Clock);
    xmit_go[i] = 1'b0;
    while (tx_empty[i] === 1'b0 && low < 1000) begin
      if (low % CPB_A[i] == CPB_A[i] / 2 && low / CPB_A[i] < 12)
        seq[4'(low / CPB_A[i])] = txd[i];
      low++;
      @(negedge Clock);
    end
  endtask

  // Line model: a frame is a fixed list of bit levels, each held CPB cycles.
  initial begin
    for (int i = 0; i < NI; i++) pos[i] = -1;
    forever @(posedge Clock) begin
      for (int i = 0; i < NI; i++) begin
        if (Reset) pos[i] = -1;
        else if (pos[i] < 0) begin
          if (xmit_go[i]) begin
            fbits[i] = frameBits(i, tx_data[i]);
            pos[i]   = 0;
          end
        end else begin
          pos[i]++;
          if (pos[i] == frameLen(i)) pos[i] = -1;
        end
      end
    end
  end

  initial begin
    forever @(negedge Clock) begin
      if (check_en) begin
        for (int i = 0; i < NI; i++) begin
          logic exp_txd;
          exp_txd = (pos[i] < 0) ? 1'b1 : fbits[i][pos[i] / CPB_A[i]];
          checkOutput($sformatf("txd[%0d]", i), 32'(txd[i]), 32'(exp_txd));
          checkOutput($sformatf("tx_empty[%0d]", i), 32'(tx_empty[i]), (pos[i] < 0) ? 1 : 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          low;
    logic [11:0] seq;
    string       msg;
    byte         exp_h [13];

    msg   = "Hello World!\n";
    exp_h = '{72, 101, 108, 108, 111, 32, 87, 111, 114, 108, 100, 33, 10};
    Reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      xmit_go[i] = 1'b0;
      tx_data[i] = 8'h00;
    end
    repeat (2) @(negedge Clock);
    check_en = 1;
    checkOutput("reset txd", 32'(txd[0]), 1);
    checkOutput("reset tx_empty", 32'(tx_empty[0]), 1);
    Reset = 1'b0;
    @(negedge Clock);

    measureFrame(0, 8'h48, low, seq);
    checkOutput("0x48 none len", low, 40);
    checkOutput("0x48 none bits", 32'(seq), 32'h290);
    checkOutput("0x48 none idle txd", 32'(txd[0]), 1);
    measureFrame(1, 8'h48, low, seq);
    checkOutput("0x48 even len", low, 44);
    checkOutput("0x48 even bits", 32'(seq), 32'h490);
    measureFrame(2, 8'h48, low, seq);
    checkOutput("0x48 odd len", low, 44);
    checkOutput("0x48 odd bits", 32'(seq), 32'h690);
    measureFrame(1, 8'h49, low, seq);
    checkOutput("0x49 even len", low, 44);
    checkOutput("0x49 even bits", 32'(seq), 32'h692);
    measureFrame(3, 8'h00, low, seq);
    checkOutput("0x00 stop2 len", low, 44);
    checkOutput("0x00 stop2 bits", 32'(seq), 32'h600);

    // Back-to-back frames with the request held and data changed mid-frame.
    xmit_go[0] = 1'b1;
    tx_data[0] = 8'h55;
    @(negedge Clock);
    repeat (10) @(negedge Clock);
    tx_data[0] = 8'hAA;
    waitEmpty(0, "b2b first frame end");
    @(negedge Clock);
    checkOutput("b2b restart tx_empty", 32'(tx_empty[0]), 0);
    checkOutput("b2b restart txd", 32'(txd[0]), 0);
    xmit_go[0] = 1'b0;
    waitEmpty(0, "b2b second frame end");

    // Reset during data bit 3 aborts the frame.
    @(negedge Clock);
    xmit_go[0] = 1'b1;
    tx_data[0] = 8'h5A;
    @(negedge Clock);
    xmit_go[0] = 1'b0;
    repeat (17) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    checkOutput("abort txd", 32'(txd[0]), 1);
    checkOutput("abort tx_empty", 32'(tx_empty[0]), 1);
    measureFrame(0, 8'h41, low, seq);
    checkOutput("0x41 after abort len", low, 40);
    checkOutput("0x41 after abort bits", 32'(seq), 32'h282);

    // Reset wins over an accept in the same cycle.
    Reset      = 1'b1;
    xmit_go[1] = 1'b1;
    @(negedge Clock);
    Reset      = 1'b0;
    xmit_go[1] = 1'b0;
    checkOutput("reset vs accept", 32'(tx_empty[1]), 1);
    @(negedge Clock);

    // Message driver and line decoder on the 50-cycle instance.
    fork
      begin
        for (int k = 0; k < msg.len(); k++) begin
          int n;
          waitEmpty(4, "hello ready");
          xmit_go[4] = 1'b1;
          tx_data[4] = msg[k];
          n = 0;
          @(negedge Clock);
          while (tx_empty[4] !== 1'b0 && n < 10) begin
            @(negedge Clock);
            n++;
          end
          xmit_go[4] = 1'b0;
        end
      end
      begin
        for (int k = 0; k < 13; k++) begin
          int         n;
          logic [7:0] b;
          n = 0;
          b = '0;
          while (txd[4] !== 1'b0 && n < 5000) begin
            @(negedge Clock);
            n++;
          end
          repeat (25) @(negedge Clock);
          for (int j = 0; j < 8; j++) begin
            repeat (50) @(negedge Clock);
            b[j] = txd[4];
          end
          checkOutput($sformatf("hello byte %0d", k), 32'(b), 32'(exp_h[k]));
          repeat (50) @(negedge Clock);
          checkOutput("hello stop", 32'(txd[4]), 1);
        end
      end
    join
    waitEmpty(4, "hello done");

    repeat (4000) begin
      @(negedge Clock);
      applyStimulus();
    end
    @(negedge Clock);
    Reset = 1'b0;
    for (int i = 0; i < NI; i++) xmit_go[i] = 1'b0;
    for (int i = 0; i < NI; i++) waitEmpty(i, "random drain");
    repeat (3) @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit serializer: accepts one byte per XMitGo/TxEmpty handshake and shifts it out on TxD as an asynchronous serial frame. The frame is a start bit, 8 data bits LSB first, an optional parity bit, and 1 or 2 stop bits. It sits directly downstream of the message-ROM TX driver, consuming its XMitGo/TxData and producing the TxEmpty status that driver waits on. TxD drives the board's UART/USB bridge pin.

## Interface
- CLKS_PER_BIT, default 434: Clock cycles per bit period (50 MHz / 115200 ≈ 434). Must be ≥ 2; elaboration error otherwise.
- PARITY, default 0: 0 = none, 1 = even, 2 = odd. Any other value is an elaboration error.
- STOP_BITS, default 1: number of stop bits, 1 or 2. Any other value is an elaboration error.

- Clock  in  1  system clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high.
- XMitGo  in  1  transmit request, level-sensitive; sampled only while TxEmpty=1.
- TxData  in  8  byte to send; sampled only on the accept edge.
- TxD  out  1  serial line; registered, idles high.
- TxEmpty  out  1  1 = idle and ready to accept; 0 = frame in progress. Registered.

## Operation
- State machine: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TxD=1, TxEmpty=1.
  - Accept edge: state=IDLE and XMitGo=1. On this edge:
    - latch TxData into the shift register;
    - compute the parity bit from TxData: even = XOR of the bits, odd = its inverse;
    - TxD<=0, TxEmpty<=0, baud counter<=0, state<=START.
  - START to DATA: after CLKS_PER_BIT cycles. Bit index <= 0; TxD <= shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, then shift right and increment the index. After bit 7 is complete:
    - go to PARITY if PARITY≠0, with TxD=parity bit;
    - otherwise go to STOP, with TxD=1.
  - PARITY: held CLKS_PER_BIT cycles, then go to STOP with TxD=1.
  - STOP: held CLKS_PER_BIT×STOP_BITS cycles. On the final edge: state<=IDLE, TxEmpty<=1, TxD stays 1.
- XMitGo and TxData are ignored whenever TxEmpty=0. Changing TxData mid-frame has no effect on the frame.
- XMitGo still high on the first IDLE cycle after a frame accepts a new frame at that edge. The result is back-to-back frames with zero idle gap, and this is legal.
- Baud counter:
  - width $clog2(CLKS_PER_BIT);
  - counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary;
  - no overflow is possible.
- Stop-bit counter: 1 bit, used only when STOP_BITS=2.

## Timing
- Reset values: TxD=1, TxEmpty=1, state=IDLE, all counters 0, shift register 0.
- Reset mid-frame aborts the frame. TxD=1 and TxEmpty=1 after the reset edge, and no partial bits follow.
- Reset has priority over an accept in the same cycle.
- Latency: TxD falls on the accept edge itself, so the start bit is visible in the cycle after accept.
- Frame length: F = CLKS_PER_BIT × (1 + 8 + (PARITY≠0) + STOP_BITS) cycles.
  - TxEmpty is low for exactly F cycles.
  - It returns high on the edge that ends the last stop bit.
- Every bit lasts exactly CLKS_PER_BIT cycles, with no jitter.
- Handshake with the TX driver: the driver holds XMitGo until it sees TxEmpty=0, one cycle after accept. That cycle falls within the start bit, so no duplicate accept occurs.

## Test plan
- CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1; pulse XMitGo with TxData=0x48.
  - TxD sequence, one value per 4 cycles: 0 | 0,0,0,1,0,0,1,0 | 1.
  - TxEmpty is low for 40 cycles, then high. TxD is 1 afterwards.
- Same byte with PARITY=1 gives parity bit 0; with PARITY=2 gives parity bit 1.
  - Frame is 44 cycles.
  - Repeat with 0x49 and PARITY=1: parity bit 1.
- STOP_BITS=2 with 0x00: start and data bits are low for 36 cycles, then TxD is high for 8 cycles. TxEmpty is low for 44 cycles total.
- XMitGo held high continuously with TxData=0x55: frames repeat with no idle cycle. The next start bit begins in the cycle after TxEmpty=1.
  - Change TxData to 0xAA mid-frame: the current frame still sends 0x55, and the next frame sends 0xAA.
- Assert Reset during data bit 3: next cycle TxD=1 and TxEmpty=1.
  - A new XMitGo with 0x41 then produces a clean, full frame.
- Connect the TX driver with DIVISOR=50 and ROM "Hello World!\n". Decode TxD in the bench: it must recover 72,101,108,108,111,32,87,111,114,108,100,33,10 in order.
